// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer driving the instruction ROM address.
// Optional dynamic instruction counter built when INSTR_FETCH_PERF_CNT_EN is defined.
module instr_fetch #(
   parameter int PC_W       = 10,
   parameter int PROG_DEPTH = 512,
   parameter int START_ADDR = 0,
   parameter int CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic [PC_W-1:0]  BranchTarget,
   output logic [PC_W-1:0]  InstAddress,
   output logic             Running,
   output logic             Done,
   output logic             Fault,
   output logic [CNT_W-1:0] DynInstCount,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_DEPTH - 1);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic            target_ok;

   // Control semantics: Start is a level sampled only in IDLE/DONE; in RUN the
   // decoder inputs are sampled every cycle with priority Halt > Stall > BranchEn
   // > end-of-program check > sequential step. There is no back-pressure path.
   assign target_ok = (32'(BranchTarget) < 32'(PROG_DEPTH));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         pc    <= START_PC;
         Done  <= 1'b0;
         Fault <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state <= RUN;
                  pc    <= START_PC;
                  Done  <= 1'b0;
                  Fault <= 1'b0;
               end
            end
            RUN: begin
               if (Halt) begin
                  state <= DONE;
                  Done  <= 1'b1;
               end else if (Stall) begin
                  // Branch ignored here; the decoder re-presents it after the stall.
                  pc <= pc;
               end else if (BranchEn) begin
                  if (target_ok) begin
                     pc <= BranchTarget;
                  end else begin
                     state <= DONE;
                     Done  <= 1'b1;
                     Fault <= 1'b1;
                  end
               end else if (pc == LAST_PC) begin
                  state <= DONE;
                  Done  <= 1'b1;
                  Fault <= 1'b1;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign InstAddress = pc;
   assign Running     = (state == RUN);
   assign state_dbg   = state;

`ifdef INSTR_FETCH_PERF_CNT_EN
   logic             advance;
   logic             launch;
   logic [CNT_W-1:0] cnt;

   // Mirrors the PC-advancing branches of the RUN priority chain.
   always_comb begin
      advance = 1'b0;
      if (state == RUN && !Halt && !Stall) begin
         if (BranchEn) advance = target_ok;
         else          advance = (pc != LAST_PC);
      end
   end

   assign launch = (state != RUN) && Start;

   always_ff @(posedge Clk) begin
      if (Reset || launch) begin
         cnt <= '0;
      end else if (advance && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign DynInstCount = cnt;
`else
   assign DynInstCount = '0;
`endif

endmodule
